speed_mode_controller: RTL and testbench

//   Front-panel sequencer for the tick timer. Debounces one push button.

---
 rtl/speed_mode_controller.sv | 148 ++++++++++++++
 tb/tb_speed_mode_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_mode_controller.sv
// speed_mode_controller
//   Front-panel sequencer for the tick timer. A bouncy active-low push
//   button is synchronised and debounced. Each accepted press steps the
//   timer speed OFF -> SLOW -> MEDIUM -> FAST -> OFF. While the speed is not
//   OFF, the timer's tick pulse rotates a one-hot LED chaser.
//
//   Optional feature (macro LONG_PRESS_EN): holding the debounced button for
//   LONG_PRESS_CYCLES forces the speed back to OFF. The hold fires once per
//   press and re-arms only after release. With the macro undefined, hold
//   duration has no effect beyond the single press.
//
// Ports
//   clk           in   1      system clock, rising edge
//   reset_n       in   1      asynchronous reset, active low
//   btn_n         in   1      raw push button, active low, asynchronous
//   tick          in   1      1-cycle pulse from the timer
//   speed_select  out  2      00 OFF, 01 SLOW, 10 MEDIUM, 11 FAST (registered,
//                            equal to the FSM state, so it also serves as
//                            the state observation point)
//   led           out  LED_W  chaser pattern (registered)
//   mode_change   out  1      1-cycle pulse in the first cycle of a new speed
//
// Handshake: none. tick and the internal press event are single-cycle
// strobes with no back-pressure. A strobe is consumed on the edge where it
// is high, and it is dropped if higher-priority logic claims that edge.
module speed_mode_controller #(
    parameter int CLK_FREQ_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYCLES   = CLK_FREQ_HZ / 50,
    parameter int LED_W             = 8,
    parameter int LONG_PRESS_CYCLES = CLK_FREQ_HZ
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_n,
    input  logic             tick,
    output logic [1:0]       speed_select,
    output logic [LED_W-1:0] led,
    output logic             mode_change
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);

    // Elaboration-time guard on the parameter ranges the logic relies on.
    if (CLK_FREQ_HZ < 1 || DEBOUNCE_CYCLES < 2 || LED_W < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
        $error("speed_mode_controller: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_SLOW   = 2'b01,
        S_MEDIUM = 2'b10,
        S_FAST   = 2'b11
    } state_t;

    logic             sync_meta;
    logic             sync;
    logic             stable;
    logic             stable_d;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;
    logic             long_fire;
    state_t           state;
    state_t           next_state;

    // Synchroniser and debounce. A level is accepted only after the
    // synchronised input has differed from the accepted level for
    // DEBOUNCE_CYCLES consecutive cycles. Any return to the accepted level
    // restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
            stable    <= 1'b1;
            stable_d  <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            sync_meta <= btn_n;
            sync      <= sync_meta;
            stable_d  <= stable;
            if (sync == stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable  <= sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Press is the falling edge of the debounced level. Release is ignored.
    assign press = stable_d & ~stable;

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // hold_cnt saturates at LONG_PRESS_CYCLES after firing. This keeps
    // long_fire from repeating until the button is released and the count
    // clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (stable) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_W'(LONG_PRESS_CYCLES)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign long_fire = ~stable && (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1));
`else
    assign long_fire = 1'b0;
`endif

    // The 2-bit state wraps naturally from FAST back to OFF.
    always_comb begin
        next_state = state_t'(state + 2'd1);
    end

    // Speed FSM with its registered outputs. Priority order: press, then
    // long-press, then tick. A tick in the same cycle as a transition is
    // dropped, so led always takes the transition value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_OFF;
            led         <= '0;
            mode_change <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            if (press) begin
                state       <= next_state;
                mode_change <= 1'b1;
                led         <= (next_state == S_OFF) ? '0 : LED_W'(1);
            end else if (long_fire && state != S_OFF) begin
                state       <= S_OFF;
                mode_change <= 1'b1;
                led         <= '0;
            end else if (tick && state != S_OFF) begin
                led <= {led[LED_W-2:0], led[LED_W-1]};
            end
        end
    end

    assign speed_select = state;

endmodule

// File: tb/tb_speed_mode_controller.sv
// Bench for speed_mode_controller. It uses a small debounce window, a 4-bit
// chaser and a 16-cycle long press. A behavioural model tracks the speed as
// a number and the chaser as a bit position, and it is compared with the
// DUT on every falling edge. Directed phases add literal expectations.
module tb_speed_mode_controller;

    localparam int DB = 4;
    localparam int LW = 4;
    localparam int LP = 16;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          btn_n   = 1'b1;
    logic          tick    = 1'b0;
    logic [1:0]    speed_select;
    logic [LW-1:0] led;
    logic          mode_change;

    int errors   = 0;
    int checks   = 0;
    int mc_count = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    speed_mode_controller #(
        .CLK_FREQ_HZ      (1000),
        .DEBOUNCE_CYCLES  (DB),
        .LED_W            (LW),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_n       (btn_n),
        .tick        (tick),
        .speed_select(speed_select),
        .led         (led),
        .mode_change (mode_change)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    //   m_p0/m_p1 : btn_n as seen through the two synchroniser stages
    //   win       : the last DB synchronised samples. The debounced level
    //               flips when every sample in the window differs from it.
    //   m_speed   : 0..3. m_pos is the index of the lit chaser bit.
    // ------------------------------------------------------------------
    int m_p0, m_p1, m_stable, m_speed, m_pos, m_chg, m_press_pend, m_low_edges;
    int win[$];

    always @(posedge clk or negedge reset_n) begin : model
        int fire;
        int seen;
        bit all_diff;
        if (!reset_n) begin
            m_p0 = 1; m_p1 = 1; m_stable = 1;
            m_speed = 0; m_pos = 0; m_chg = 0;
            m_press_pend = 0; m_low_edges = 0;
            win.delete();
        end else begin
            fire = 0;
`ifdef LONG_PRESS_EN
            if (m_stable == 0) begin
                m_low_edges++;
                if (m_low_edges == LP) fire = 1;
            end else begin
                m_low_edges = 0;
            end
`endif
            m_chg = 0;
            if (m_press_pend != 0) begin
                m_speed = (m_speed + 1) % 4;
                m_pos   = 0;
                m_chg   = 1;
            end else if (fire != 0 && m_speed != 0) begin
                m_speed = 0;
                m_chg   = 1;
            end else if (tick && m_speed != 0) begin
                m_pos = (m_pos + 1) % LW;
            end
            seen = m_p1;
            m_p1 = m_p0;
            m_p0 = int'(btn_n);
            win.push_back(seen);
            if (win.size() > DB) void'(win.pop_front());
            m_press_pend = 0;
            if (win.size() == DB) begin
                all_diff = 1'b1;
                foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
                if (all_diff) begin
                    m_press_pend = (m_stable == 1) ? 1 : 0;
                    m_stable     = 1 - m_stable;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    logic [LW-1:0] exp_led;
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_led = (m_speed == 0) ? '0 : (LW'(1) << m_pos);
            checks++;
            if (speed_select !== 2'(m_speed) || led !== exp_led || mode_change !== m_chg[0]) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got speed=%b led=%b mc=%b, expected speed=%b led=%b mc=%b",
                         $time, speed_select, led, mode_change, 2'(m_speed), exp_led, m_chg[0]);
            end
        end
    end

    // Counts mode_change pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1 mc_count += int'(mode_change);
    end

    // ------------------------------------------------------------------
    // Driver tasks. Each task starts and ends on a falling edge.
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("reset_outputs", {25'd0, speed_select, led, mode_change}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input int low_cycles);
        btn_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stimulus
        int mc0;
        int exp_seq[5];
        exp_seq = '{2, 4, 8, 1, 2};

        // 1. Reset state. Ticks in OFF are ignored.
        do_reset();
        cmp_en = 1'b1;
        chk("reset_speed", 32'(speed_select), 32'd0);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_mc", 32'(mode_change), 32'd0);
        repeat (3) tick_pulse();
        chk("off_ticks_led", 32'(led), 32'd0);

        // 2. First press. Latency is DB+3 edges, and mode_change lasts one cycle.
        mc0 = mc_count;
        btn_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("latency_edge6_speed", 32'(speed_select), 32'd0);
        @(negedge clk);
        chk("latency_edge7_speed", 32'(speed_select), 32'd1);
        chk("latency_edge7_led", 32'(led), 32'd1);
        chk("latency_edge7_mc", 32'(mode_change), 32'd1);
        @(negedge clk);
        chk("mc_one_cycle", 32'(mode_change), 32'd0);
        repeat (2) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mc_pulse_count", 32'(mc_count - mc0), 32'd1);
        press(10);
        chk("press2_speed", 32'(speed_select), 32'd2);
        press(10);
        chk("press3_speed", 32'(speed_select), 32'd3);
        chk("press3_led", 32'(led), 32'd1);
        press(10);
        chk("press4_speed", 32'(speed_select), 32'd0);
        chk("press4_led", 32'(led), 32'd0);

        // 3. Bounces shorter than the debounce window are rejected.
        mc0 = mc_count;
        press(3);
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        @(negedge clk);
        press(3);
        chk("bounce_speed", 32'(speed_select), 32'd0);
        chk("bounce_mc", 32'(mc_count - mc0), 32'd0);

        // 4. Chaser rotation in SLOW, wrapping MSB into LSB.
        press(10);
        chk("slow_speed", 32'(speed_select), 32'd1);
        chk("slow_led", 32'(led), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick_pulse();
            chk($sformatf("rotate_%0d", i), 32'(led), 32'(exp_seq[i]));
        end

        // 5. A tick coincident with the press-accepting edge is dropped.
        btn_n = 1'b0;
        repeat (6) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("coinc_speed", 32'(speed_select), 32'd2);
        chk("coinc_led", 32'(led), 32'd1);
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        tick_pulse();
        chk("after_coinc_led", 32'(led), 32'd2);

`ifdef LONG_PRESS_EN
        // 6. A long press from OFF: SLOW at edge 7, OFF at edge 22, once.
        do_reset();
        mc0 = mc_count;
        btn_n = 1'b0;
        repeat (7) @(negedge clk);
        chk("long_edge7_speed", 32'(speed_select), 32'd1);
        repeat (14) @(negedge clk);
        chk("long_edge21_speed", 32'(speed_select), 32'd1);
        @(negedge clk);
        chk("long_edge22_speed", 32'(speed_select), 32'd0);
        chk("long_edge22_led", 32'(led), 32'd0);
        chk("long_edge22_mc", 32'(mode_change), 32'd1);
        repeat (18) @(negedge clk);
        btn_n = 1'b1;
        chk("long_held_speed", 32'(speed_select), 32'd0);
        chk("long_mc_count", 32'(mc_count - mc0), 32'd2);
        repeat (12) @(negedge clk);
        press(10);
        chk("long_repress_speed", 32'(speed_select), 32'd1);
        // Reset in the middle of a hold.
        btn_n = 1'b0;
        repeat (20) @(negedge clk);
        do_reset();
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("long_reset_speed", 32'(speed_select), 32'd0);
`endif

        // 7. Random holds, releases, ticks and occasional resets.
        for (int it = 0; it < 60; it++) begin
            btn_n = 1'b0;
            rand_cycles($urandom_range(1, 30));
            if ($urandom_range(0, 14) == 0) do_reset();
            btn_n = 1'b1;
            rand_cycles($urandom_range(1, 20));
        end
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
